// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer-side write port of the buffered UART transmitter
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] data;
  logic                 start;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic                 overflow;

  modport master (output data, start, input full, empty, count, overflow);
  modport slave  (input data, start, output full, empty, count, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with configurable framing
// Queued words stream back-to-back; the FIFO count excludes the word in the shifter.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic           clock,
  input  logic           reset,
  uart_tx_fifo_if.slave  wr,
  output logic           tx,
  output logic           busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic                 push, pop, bit_end;

  always_comb begin
    push     = wr.start & ~full_q;
    pop      = 1'b0;
    bit_end  = (timer_q == TW'(CLKS_PER_BIT - 1));
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // All stop bits share one timer span so the last cycle is a single compare.
        if (timer_q == TW'(STOP_BITS * CLKS_PER_BIT - 1)) begin
          timer_d = '0;
          if (!empty_q) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
      par_d    = (^mem_q[rd_ptr_q]) ^ (PARITY == 1);
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CW'(FIFO_DEPTH));
    empty_d = (count_d == '0);
    ovf_d   = wr.start & full_q;

    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) | ~empty_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr.data;
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign wr.full     = full_q;
  assign wr.empty    = empty_q;
  assign wr.count    = count_q;
  assign wr.overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo in 8N1 and 8E2 framings
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic clock = 1'b0;
  logic rst0, rst1, tx0, tx1, busy0, busy1;
  always #5 clock = ~clock;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if1 ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
    dut0 (.clock(clock), .reset(rst0), .wr(if0), .tx(tx0), .busy(busy0));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16))
    dut1 (.clock(clock), .reset(rst1), .wr(if1), .tx(tx1), .busy(busy1));

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  always @(posedge clock) cyc_n++;

  logic [11:0] rx0[$], rx1[$];
  int          rxt0[$];
  logic [7:0]  exp0[$];
  logic [11:0] exp1[$];

  // Line monitors: sample each bit mid-cell, frame bit 0 is the start bit.
  bit m0_in = 0, m1_in = 0;
  int m0_c, m1_c, m0_t;
  logic [11:0] m0_sh, m1_sh;
  always @(negedge clock) begin
    if (rst0) m0_in = 0;
    else begin
      if (!m0_in && tx0 === 1'b0) begin m0_in = 1; m0_c = 0; m0_t = cyc_n; m0_sh = '0; end
      if (m0_in) begin
        if (m0_c % CPB == CPB / 2) m0_sh[m0_c / CPB] = tx0;
        if (m0_c == 10 * CPB - 1) begin rx0.push_back(m0_sh); rxt0.push_back(m0_t); m0_in = 0; end
        m0_c++;
      end
    end
  end
  always @(negedge clock) begin
    if (rst1) m1_in = 0;
    else begin
      if (!m1_in && tx1 === 1'b0) begin m1_in = 1; m1_c = 0; m1_sh = '0; end
      if (m1_in) begin
        if (m1_c % CPB == CPB / 2) m1_sh[m1_c / CPB] = tx1;
        if (m1_c == 12 * CPB - 1) begin rx1.push_back(m1_sh); m1_in = 0; end
        m1_c++;
      end
    end
  end

  task automatic do_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    if0.start = 1'b0; if1.start = 1'b0;
    repeat (2) @(negedge clock);
    rst0 = 1'b0; rst1 = 1'b0;
    rx0.delete(); rxt0.delete(); rx1.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    if0.start = 1'b0; if0.data = '0; if1.start = 1'b0; if1.data = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({tx0, busy0, if0.full, if0.empty, if0.count, if0.overflow} !== {4'b1001, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_dut0 got tx=%b busy=%b full=%b empty=%b count=%0d ovf=%b exp 1 0 0 1 0 0",
               tx0, busy0, if0.full, if0.empty, if0.count, if0.overflow);
    end
    checks++;
    if ({tx1, busy1, if1.full, if1.empty, if1.count, if1.overflow} !== {4'b1001, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_dut1 got tx=%b busy=%b full=%b empty=%b count=%0d ovf=%b exp 1 0 0 1 0 0",
               tx1, busy1, if1.full, if1.empty, if1.count, if1.overflow);
    end
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clock);
    checks++;
    if ({tx0, busy0, if0.empty} !== 3'b101) begin
      errors++;
      $display("FAIL reset_release_idle got tx=%b busy=%b empty=%b exp 1 0 1", tx0, busy0, if0.empty);
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] fr;
    int bad;
    do_reset();
    fr = {1'b1, 8'h55, 1'b0};
    @(negedge clock); if0.data = 8'h55; if0.start = 1'b1;
    @(negedge clock); if0.start = 1'b0;
    checks++;
    if ({tx0, busy0, if0.empty, if0.count} !== {3'b100, 5'd1}) begin
      errors++;
      $display("FAIL write_latency got tx=%b busy=%b empty=%b count=%0d exp 1 0 0 1", tx0, busy0, if0.empty, if0.count);
    end
    bad = 0;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clock);
      if (tx0 !== fr[k / CPB] || busy0 !== 1'b1) begin
        if (bad == 0) $display("FAIL frame_55_wave cycle %0d got tx=%b busy=%b exp tx=%b busy=1", k, tx0, busy0, fr[k / CPB]);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    @(negedge clock);
    checks++;
    if ({tx0, busy0, if0.empty, if0.count} !== {3'b101, 5'd0}) begin
      errors++;
      $display("FAIL frame_55_end got tx=%b busy=%b empty=%b count=%0d exp 1 0 1 0", tx0, busy0, if0.empty, if0.count);
    end
    checks++;
    if (rx0.size() != 1 || rx0[0] !== 12'({1'b1, 8'h55, 1'b0})) begin
      errors++;
      $display("FAIL frame_55_rx got n=%0d frame=%h exp n=1 frame=%h", rx0.size(), (rx0.size() > 0) ? rx0[0] : 12'hxxx, 12'({1'b1, 8'h55, 1'b0}));
    end
  endtask

  task automatic test_parity();
    logic [7:0] vals [4];
    int n;
    do_reset();
    vals[0] = 8'h07; vals[1] = 8'h00; vals[2] = 8'hFF; vals[3] = 8'h80;
    @(negedge clock); if1.data = vals[0]; if1.start = 1'b1; exp1.push_back({2'b11, ^vals[0], vals[0], 1'b0});
    @(negedge clock); if1.start = 1'b0;
    n = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (busy1) n++;
      else if (n > 0) break;
    end
    checks++;
    if (n != 12 * CPB) begin
      errors++;
      $display("FAIL parity_busy_len got %0d exp %0d", n, 12 * CPB);
    end
    for (int i = 1; i < 4; i++) begin
      @(negedge clock); if1.data = vals[i]; if1.start = 1'b1; exp1.push_back({2'b11, ^vals[i], vals[i], 1'b0});
    end
    @(negedge clock); if1.start = 1'b0;
    for (int t = 0; t < 400 && rx1.size() < 4; t++) @(negedge clock);
    checks++;
    if (rx1.size() != 4) begin
      errors++;
      $display("FAIL parity_frame_count got %0d exp 4", rx1.size());
    end
    while (rx1.size() > 0 && exp1.size() > 0) begin
      logic [11:0] got, want;
      got = rx1.pop_front(); want = exp1.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL parity_frame got %h exp %h", got, want);
      end
    end
  endtask

  task automatic test_overflow();
    int ovf_n, maxc;
    do_reset();
    ovf_n = 0; maxc = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      if (if0.overflow) ovf_n++;
      if (int'(if0.count) > maxc) maxc = int'(if0.count);
      if (i == 17) begin
        checks++;
        if ({if0.full, if0.count} !== {1'b1, 5'd16}) begin
          errors++;
          $display("FAIL ovf_full got full=%b count=%0d exp 1 16", if0.full, if0.count);
        end
      end
      if0.data = 8'(i); if0.start = 1'b1;
      if (i < 17) exp0.push_back(8'(i));
    end
    @(negedge clock); if0.start = 1'b0;
    checks++;
    if ({if0.overflow, if0.full, if0.count} !== {2'b11, 5'd16}) begin
      errors++;
      $display("FAIL ovf_pulse got ovf=%b full=%b count=%0d exp 1 1 16", if0.overflow, if0.full, if0.count);
    end
    if (if0.overflow) ovf_n++;
    for (int t = 0; t < 17 * 10 * CPB + 100 && rx0.size() < 17; t++) begin
      @(negedge clock);
      if (if0.overflow) ovf_n++;
      if (int'(if0.count) > maxc) maxc = int'(if0.count);
    end
    checks++;
    if (ovf_n != 1 || maxc != 16) begin
      errors++;
      $display("FAIL ovf_once got pulses=%0d peak=%0d exp 1 16", ovf_n, maxc);
    end
    checks++;
    if (rx0.size() != 17) begin
      errors++;
      $display("FAIL ovf_frame_count got %0d exp 17", rx0.size());
    end
    for (int k = 1; k < rxt0.size(); k++) begin
      checks++;
      if (rxt0[k] - rxt0[k-1] != 10 * CPB) begin
        errors++;
        $display("FAIL ovf_gap frame %0d got spacing %0d exp %0d", k, rxt0[k] - rxt0[k-1], 10 * CPB);
      end
    end
    while (rx0.size() > 0 && exp0.size() > 0) begin
      logic [11:0] got;
      logic [7:0]  want;
      got = rx0.pop_front(); want = exp0.pop_front();
      checks++;
      if (got !== 12'({1'b1, want, 1'b0})) begin
        errors++;
        $display("FAIL ovf_data got %h exp %h", got, 12'({1'b1, want, 1'b0}));
      end
    end
  endtask

  task automatic test_wrap();
    int sent, ovf_n, maxc;
    logic [7:0] v;
    do_reset();
    sent = 0; ovf_n = 0; maxc = 0;
    for (int t = 0; t < 3000 && (sent < 40 || rx0.size() < 40); t++) begin
      @(negedge clock);
      if (if0.overflow) ovf_n++;
      if (int'(if0.count) > maxc) maxc = int'(if0.count);
      if (sent < 40 && !if0.full && t % 2 == 0) begin
        v = 8'($urandom_range(0, 255));
        if0.data = v; if0.start = 1'b1; exp0.push_back(v); sent++;
      end else begin
        if0.start = 1'b0;
      end
    end
    if0.start = 1'b0;
    checks++;
    if (rx0.size() != 40 || ovf_n != 0 || maxc != 16) begin
      errors++;
      $display("FAIL wrap_summary got frames=%0d ovf=%0d peak=%0d exp 40 0 16", rx0.size(), ovf_n, maxc);
    end
    while (rx0.size() > 0 && exp0.size() > 0) begin
      logic [11:0] got;
      logic [7:0]  want;
      got = rx0.pop_front(); want = exp0.pop_front();
      checks++;
      if (got !== 12'({1'b1, want, 1'b0})) begin
        errors++;
        $display("FAIL wrap_data got %h exp %h", got, 12'({1'b1, want, 1'b0}));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w [4];
    int bad;
    do_reset();
    w[0] = 8'hA5; w[1] = 8'h11; w[2] = 8'h22; w[3] = 8'h33;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); if0.data = w[i]; if0.start = 1'b1;
    end
    @(negedge clock); if0.start = 1'b0;
    repeat (15) @(negedge clock);
    checks++;
    if ({tx0, if0.count} !== {w[0][3], 5'd3}) begin
      errors++;
      $display("FAIL midframe_pre got tx=%b count=%0d exp %b 3", tx0, if0.count, w[0][3]);
    end
    rst0 = 1'b1;
    @(negedge clock);
    checks++;
    if ({tx0, busy0, if0.empty, if0.count} !== {3'b101, 5'd0}) begin
      errors++;
      $display("FAIL midframe_reset got tx=%b busy=%b empty=%b count=%0d exp 1 0 1 0", tx0, busy0, if0.empty, if0.count);
    end
    @(negedge clock); rst0 = 1'b0;
    bad = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || rx0.size() != 0) begin
      errors++;
      $display("FAIL midframe_quiet got active_cycles=%0d frames=%0d exp 0 0", bad, rx0.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_overflow();
    test_wrap();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
